// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 DIT FFT sequencer.
//   STAGE  : log2 of the transform length (number of FFT stages)
//   N      : transform length, 2**STAGE
//   BITS   : sample word width used by the datapath around the sequencer
//   BF_LAT : butterfly pipeline latency, issue to write-back, in cycles
//   seq_state_t : sequencer FSM states
//   addr_t      : sample RAM address
//   tw_idx_t    : twiddle LUT index (one bit wider than an address)
// ----------------------------------------------------------------------------
package fft_pkg;

  localparam int STAGE  = 4;
  localparam int N      = 1 << STAGE;
  localparam int BITS   = 16;
  localparam int BF_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef logic [STAGE-1:0] addr_t;
  typedef logic [STAGE:0]   tw_idx_t;

endpackage

// File: rtl/fft_wb_delay.sv
// ----------------------------------------------------------------------------
// fft_wb_delay
// Fixed-depth delay line that carries each accepted butterfly issue
// {valid, addr_a, addr_b} to the write-back side. It shifts every cycle,
// regardless of datapath stall, so write-back timing matches the butterfly
// pipeline exactly.
// Ports:
//   clk, rst                 : clock, asynchronous active-high clear
//   in_valid/in_addr_a/b     : accepted issue entering the line
//   out_valid/out_addr_a/b   : the same issue DEPTH cycles later
// ----------------------------------------------------------------------------
module fft_wb_delay #(
  parameter int DEPTH = fft_pkg::BF_LAT,
  parameter int AW    = fft_pkg::STAGE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  localparam int W = 2 * AW + 1;

  // tap_w[i] is the content of tap i; tap 0 is loaded from the input.
  logic [W-1:0] tap_w [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_tap
    logic [W-1:0] tap_q;
    logic [W-1:0] tap_d;

    if (gi == 0) begin : g_head
      assign tap_d = {in_valid, in_addr_a, in_addr_b};
    end else begin : g_body
      assign tap_d = tap_w[gi-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tap_q <= '0;
      end else begin
        tap_q <= tap_d;
      end
    end

    assign tap_w[gi] = tap_q;
  end

  assign {out_valid, out_addr_a, out_addr_b} = tap_w[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fft_seq_ctrl
// Sequencer for an in-place radix-2 decimation-in-time FFT. Walks every
// stage s and butterfly k, issuing the operand addresses and twiddle index,
// returns the matching write-back addresses BF_LAT cycles after each
// accepted issue, and drains the butterfly pipeline between stages so no
// stage reads a location before the previous stage has written it.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start            : begin a transform (only looked at in IDLE)
//   stall            : datapath not ready; issue accepted on bf_valid & !stall
//   busy             : high while running or draining
//   done             : one-cycle pulse after the final drain
//   bf_valid         : addr_a/addr_b/tw_index carry a butterfly issue
//   addr_a, addr_b   : upper / lower operand addresses
//   tw_index         : twiddle LUT index
//   stage_num        : current stage
//   wb_valid         : write-back strobe
//   wb_addr_a/b      : write-back addresses for the upper / lower result
// ----------------------------------------------------------------------------
module fft_seq_ctrl #(
  parameter  int STAGE  = fft_pkg::STAGE,
  parameter  int BF_LAT = fft_pkg::BF_LAT,
  localparam int SW     = (STAGE > 1) ? $clog2(STAGE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  output logic [STAGE-1:0] addr_a,
  output logic [STAGE-1:0] addr_b,
  output logic [STAGE:0]   tw_index,
  output logic [SW-1:0]    stage_num,
  output logic             wb_valid,
  output logic [STAGE-1:0] wb_addr_a,
  output logic [STAGE-1:0] wb_addr_b
);

  import fft_pkg::*;

  localparam int               CW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [STAGE-1:0] ONE    = STAGE'(1);
  localparam logic [STAGE-1:0] K_LAST = STAGE'((1 << (STAGE - 1)) - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(STAGE - 1);
  localparam logic [CW-1:0]    C_LAST = CW'(BF_LAT - 1);

  // Upper operand address: butterfly index k with a zero bit inserted at
  // position s. Bits below s select the position inside the group, bits
  // at and above s select the group (each group spans 2*half addresses).
  function automatic logic [STAGE-1:0] bf_addr_a(input logic [STAGE-1:0] k,
                                                 input logic [SW-1:0]    s);
    logic [STAGE-1:0] mask;
    mask = (ONE << s) - ONE;
    return ((k & ~mask) << 1) | (k & mask);
  endfunction

  // Twiddle index: position within the group scaled to the N-point circle.
  // The extra MSB exists only to match the LUT port and always stays 0.
  function automatic logic [STAGE:0] bf_twiddle(input logic [STAGE-1:0] k,
                                                input logic [SW-1:0]    s);
    logic [STAGE-1:0] mask;
    mask = (ONE << s) - ONE;
    return {1'b0, k & mask} << (S_LAST - s);
  endfunction

  seq_state_t       state_q, state_d;
  logic [STAGE-1:0] k_q, k_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [STAGE-1:0] addr_a_q, addr_a_d;
  logic [STAGE-1:0] addr_b_q, addr_b_d;
  logic [STAGE:0]   tw_q, tw_d;
  logic             load;
  logic             accept;

  // valid_q is only ever set in RUN, so this also masks stall elsewhere.
  assign accept = valid_q && !stall;

  // --------------------------------------------------------------------------
  // FSM, butterfly counter, stage counter and drain counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end

      RUN: begin
        if (accept) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            k_d  = k_q + ONE;
            load = 1'b1;
          end
        end
      end

      // The last write-back of the stage lands in the final DRAIN cycle,
      // so the next stage's first read is issued strictly after it.
      DRAIN: begin
        if (cnt_q == C_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
            valid_d = 1'b1;
            load    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        stage_d = '0;
        k_d     = '0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue registers: reloaded only when a new butterfly is presented, so they
  // hold steady across stalled cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_d     = tw_q;
    if (load) begin
      addr_a_d = bf_addr_a(k_d, stage_d);
      addr_b_d = addr_a_d | (ONE << stage_d);
      tw_d     = bf_twiddle(k_d, stage_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      stage_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back path: the accepted issue travels BF_LAT cycles alongside the
  // butterfly datapath.
  // --------------------------------------------------------------------------
  fft_wb_delay #(
    .DEPTH (BF_LAT),
    .AW    (STAGE)
  ) u_wb_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_addr_a  (addr_a_q),
    .in_addr_b  (addr_b_q),
    .out_valid  (wb_valid),
    .out_addr_a (wb_addr_a),
    .out_addr_b (wb_addr_b)
  );

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign bf_valid  = valid_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_index  = tw_q;
  assign stage_num = stage_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_seq_ctrl
// Three sequencers (BF_LAT = 1, 3, 6) share clock, reset and stall; each has
// its own start. A transaction-level model tracks, per instance, the
// expected butterfly order, the write-back schedule, outstanding writes per
// address (read-after-write hazards), busy/done timing and per-stage address
// coverage. Instance 1 (BF_LAT = 3) also gets directed cycle-exact checks.
// ----------------------------------------------------------------------------
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       stall;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       bfv_v   [3];
  logic       wbv_v   [3];
  logic [3:0] aa_v    [3];
  logic [3:0] ab_v    [3];
  logic [4:0] tw_v    [3];
  logic [1:0] sn_v    [3];
  logic [3:0] wa_v    [3];
  logic [3:0] wbb_v   [3];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    fft_seq_ctrl #(
      .STAGE  (4),
      .BF_LAT ((gi == 0) ? 1 : ((gi == 1) ? 3 : 6))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[gi]),
      .stall     (stall),
      .busy      (busy_v[gi]),
      .done      (done_v[gi]),
      .bf_valid  (bfv_v[gi]),
      .addr_a    (aa_v[gi]),
      .addr_b    (ab_v[gi]),
      .tw_index  (tw_v[gi]),
      .stage_num (sn_v[gi]),
      .wb_valid  (wbv_v[gi]),
      .wb_addr_a (wa_v[gi]),
      .wb_addr_b (wbb_v[gi])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, one slot per instance.
  bit          active   [3];
  int          st       [3];
  int          idx      [3];
  int          stalls   [3];
  int          wb_cnt   [3];
  int          done_cnt [3];
  logic [15:0] seen     [3];
  int          pend     [3][16];
  int          q_due    [3][128];
  int          q_a      [3][128];
  int          q_b      [3][128];
  int          qh       [3];
  int          qt       [3];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 6);
  endfunction

  // Every stage costs N/2 issues plus a BF_LAT drain, plus one DONE cycle,
  // plus every cycle an issue was held off by stall.
  function automatic int exp_done(int i);
    return st[i] + 4 * (8 + lat_of(i)) + 1 + stalls[i];
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (BF_LAT=%0d, cycle %0d): observed %0d expected %0d",
             tag, lat_of(i), cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, i, busy_v[i], 0);
      chk({tag, "_done"}, i, done_v[i], 0);
      chk({tag, "_bf_valid"}, i, bfv_v[i], 0);
      chk({tag, "_addr_a"}, i, aa_v[i], 0);
      chk({tag, "_addr_b"}, i, ab_v[i], 0);
      chk({tag, "_tw"}, i, tw_v[i], 0);
      chk({tag, "_stage"}, i, sn_v[i], 0);
      chk({tag, "_wb_valid"}, i, wbv_v[i], 0);
      chk({tag, "_wb_addr_a"}, i, wa_v[i], 0);
      chk({tag, "_wb_addr_b"}, i, wbb_v[i], 0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      active[i] = 1'b0;
      qh[i]     = 0;
      qt[i]     = 0;
      for (int a = 0; a < 16; a++) pend[i][a] = 0;
    end
  endtask

  // Check the current cycle against the model, update it, advance a cycle.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      int ed, s, k, half, pos, ea, eb, etw, h;
      bit just_done, wexp;
      ed        = exp_done(i);
      just_done = 1'b0;

      chk("busy", i, busy_v[i], active[i] && cyc > st[i] && cyc < ed);
      chk("done", i, done_v[i], active[i] && cyc == ed);

      if (bfv_v[i]) begin
        chk("issue_window", i, active[i] && idx[i] < 32 && cyc < ed, 1);
        s    = idx[i] / 8;
        k    = idx[i] % 8;
        half = 1 << s;
        pos  = k % half;
        ea   = (k / half) * 2 * half + pos;
        eb   = ea + half;
        etw  = pos * (8 / half);
        chk("addr_a", i, aa_v[i], ea);
        chk("addr_b", i, ab_v[i], eb);
        chk("tw_index", i, tw_v[i], etw);
        chk("stage_num", i, sn_v[i], s);
        chk("raw_hazard_a", i, pend[i][aa_v[i]], 0);
        chk("raw_hazard_b", i, pend[i][ab_v[i]], 0);
        if (!stall) begin
          pend[i][aa_v[i]]++;
          pend[i][ab_v[i]]++;
          q_due[i][qt[i] % 128] = cyc + lat_of(i);
          q_a[i][qt[i] % 128]   = aa_v[i];
          q_b[i][qt[i] % 128]   = ab_v[i];
          qt[i]++;
          seen[i][aa_v[i]] = 1'b1;
          seen[i][ab_v[i]] = 1'b1;
          idx[i]++;
          if (idx[i] % 8 == 0) begin
            chk("stage_coverage", i, seen[i], 16'hFFFF);
            seen[i] = '0;
          end
        end else begin
          stalls[i]++;
        end
      end

      wexp = (qh[i] != qt[i]) && (q_due[i][qh[i] % 128] == cyc);
      chk("wb_valid", i, wbv_v[i], wexp);
      if (wexp) begin
        h = qh[i] % 128;
        chk("wb_addr_a", i, wa_v[i], q_a[i][h]);
        chk("wb_addr_b", i, wbb_v[i], q_b[i][h]);
        pend[i][q_a[i][h]]--;
        pend[i][q_b[i][h]]--;
        qh[i]++;
        wb_cnt[i]++;
      end

      if (active[i] && cyc == ed) begin
        active[i] = 1'b0;
        just_done = 1'b1;
        done_cnt[i]++;
        chk("issues_per_run", i, idx[i], 32);
        chk("wb_per_run", i, wb_cnt[i], 32);
      end

      // start is honoured only in IDLE; the DONE cycle does not count.
      if (start_v[i] && !active[i] && !just_done) begin
        active[i] = 1'b1;
        st[i]     = cyc;
        idx[i]    = 0;
        stalls[i] = 0;
        wb_cnt[i] = 0;
        seen[i]   = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic start_all(bit v);
    for (int i = 0; i < 3; i++) start_v[i] = v;
  endtask

  // Stall-free transform with cycle-exact checks on the BF_LAT=3 instance.
  task automatic run_stall_free();
    int s0;
    int d0 [3];
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    stall = 1'b0;
    s0    = cyc;
    start_all(1'b1);
    tick();
    start_all(1'b0);
    chk("sf_s0k0_valid", 1, bfv_v[1], 1);
    chk("sf_s0k0_a", 1, aa_v[1], 0);
    chk("sf_s0k0_b", 1, ab_v[1], 1);
    chk("sf_s0k0_tw", 1, tw_v[1], 0);
    run_to(s0 + 13);
    chk("sf_s1k1_a", 1, aa_v[1], 1);
    chk("sf_s1k1_b", 1, ab_v[1], 3);
    chk("sf_s1k1_tw", 1, tw_v[1], 4);
    run_to(s0 + 29);
    chk("sf_s2k6_a", 1, aa_v[1], 10);
    chk("sf_s2k6_b", 1, ab_v[1], 14);
    chk("sf_s2k6_tw", 1, tw_v[1], 4);
    chk("sf_s2k6_stage", 1, sn_v[1], 2);
    run_to(s0 + 39);
    chk("sf_s3k5_a", 1, aa_v[1], 5);
    chk("sf_s3k5_b", 1, ab_v[1], 13);
    chk("sf_s3k5_tw", 1, tw_v[1], 5);
    chk("sf_s3k5_stage", 1, sn_v[1], 3);
    run_to(s0 + 44);
    chk("sf_busy_c44", 1, busy_v[1], 1);
    chk("sf_drain_no_issue", 1, bfv_v[1], 0);
    run_to(s0 + 45);
    chk("sf_done_c45", 1, done_v[1], 1);
    chk("sf_busy_c45", 1, busy_v[1], 0);
    run_to(s0 + 62);
    for (int i = 0; i < 3; i++) chk("sf_single_done", i, done_cnt[i] - d0[i], 1);
  endtask

  initial begin
    int s0;
    int d0 [3];
    bit any_active;

    rst   = 1'b1;
    stall = 1'b0;
    start_all(1'b0);
    model_reset();
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    run_to(3);

    // Stall-free transform.
    run_stall_free();

    // Stall held for 5 cycles at stage 1, k = 3 of the BF_LAT=3 instance.
    s0 = cyc;
    start_all(1'b1);
    tick();
    start_all(1'b0);
    run_to(s0 + 15);
    stall = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk("stall_valid", 1, bfv_v[1], 1);
      chk("stall_addr_a", 1, aa_v[1], 5);
      chk("stall_addr_b", 1, ab_v[1], 7);
      chk("stall_tw", 1, tw_v[1], 4);
      chk("stall_stage", 1, sn_v[1], 1);
      tick();
    end
    stall = 1'b0;
    run_to(s0 + 49);
    chk("stall_done_not_c49", 1, done_v[1], 0);
    run_to(s0 + 50);
    chk("stall_done_c50", 1, done_v[1], 1);
    run_to(s0 + 80);

    // Random stall, plus start pulses mid-run and in each DONE cycle.
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    s0 = cyc;
    start_all(1'b1);
    tick();
    start_all(1'b0);
    any_active = 1'b1;
    for (int n = 0; n < 200 && any_active; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++)
        start_v[i] = (cyc == s0 + 20) || (active[i] && cyc == exp_done(i));
      tick();
      any_active = active[0] || active[1] || active[2];
    end
    stall = 1'b0;
    start_all(1'b0);
    chk("random_run_finished", 0, any_active, 0);
    run_to(cyc + 12);
    for (int i = 0; i < 3; i++) chk("ignored_start_single_done", i, done_cnt[i] - d0[i], 1);

    // Asynchronous reset in the middle of a transform.
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    s0 = cyc;
    start_all(1'b1);
    tick();
    start_all(1'b0);
    run_to(s0 + 15);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    model_reset();
    run_to(cyc + 12);
    for (int i = 0; i < 3; i++) chk("rst_no_done", i, done_cnt[i] - d0[i], 0);
    run_stall_free();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
